// File: rtl/display_pkg.sv
// Shared constants for the six-digit seven-segment display path.
package display_pkg;

  localparam int NUM_DIGITS = 6;

  localparam logic [2:0] DIG_SEC_ONES = 3'd0;
  localparam logic [2:0] DIG_SEC_TENS = 3'd1;
  localparam logic [2:0] DIG_MIN_ONES = 3'd2;
  localparam logic [2:0] DIG_MIN_TENS = 3'd3;
  localparam logic [2:0] DIG_HR_ONES  = 3'd4;
  localparam logic [2:0] DIG_HR_TENS  = 3'd5;

  // Active-low segment patterns, bit order {CG,CF,CE,CD,CC,CB,CA}.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

endpackage

// File: rtl/seg7_decoder.sv
// BCD to active-low seven-segment decoder; codes 10..15 show blank.
module seg7_decoder
  import display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Pure lookup, anything outside 0..9 is dark.
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_scan_controller.sv
// Time-multiplexed scan of six BCD digits onto one seven-segment bus.
module display_scan_controller
  import display_pkg::*;
#(
  parameter int DIV       = 16_667,
  parameter int BLINK_DIV = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] digits_in,
  input  logic        blank_lz,
  input  logic [5:0]  blink_mask,
  output logic [2:0]  counter,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  localparam int PW = $clog2(DIV);
  localparam int BW = $clog2(BLINK_DIV);

  logic [PW-1:0] prescaler;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic [23:0]   snapshot;
  logic          tick;
  logic          frame_end;
  logic          blink_wrap;
  logic [3:0]    nibble;
  logic [6:0]    dec_seg;
  logic          blank;

  // Slot timing and blanking conditions for the digit currently selected.
  always_comb begin
    tick       = (prescaler == PW'(DIV - 1));
    frame_end  = tick && (counter == DIG_HR_TENS);
    blink_wrap = (blink_cnt == BW'(BLINK_DIV - 1));
    nibble     = snapshot[{counter, 2'b00} +: 4];
    blank      = ((counter == DIG_HR_TENS) && blank_lz && (nibble == 4'd0)) ||
                 (blink_phase && blink_mask[counter]);
  end

  seg7_decoder u_dec (
    .bcd (nibble),
    .seg (dec_seg)
  );

  // Refresh prescaler, digit select, per-frame snapshot and frame pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler   <= '0;
      counter     <= DIG_SEC_ONES;
      snapshot    <= '0;
      frame_start <= 1'b0;
    end else begin
      prescaler   <= tick ? '0 : prescaler + PW'(1);
      frame_start <= frame_end;
      if (frame_end) begin
        counter  <= DIG_SEC_ONES;
        snapshot <= digits_in;
      end else if (tick) begin
        counter <= counter + 3'd1;
      end
    end
  end

  // Free-running blink phase, independent of the scan timing.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      blink_cnt <= blink_wrap ? '0 : blink_cnt + BW'(1);
      if (blink_wrap) blink_phase <= ~blink_phase;
    end
  end

  // Output register: one clock behind counter to match the anode register.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      seg <= blank ? SEG_BLANK : dec_seg;
      dp  <= !((counter == DIG_MIN_ONES) || (counter == DIG_HR_ONES));
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// Self-checking bench for display_scan_controller with DIV=4, BLINK_DIV=32.
module tb_display_scan_controller;

  localparam int DIV   = 4;
  localparam int BLINK = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] digits_in = '0;
  logic        blank_lz = 1'b0;
  logic [5:0]  blink_mask = '0;
  logic [2:0]  counter;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [2:0] cnt;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
  } exp_t;

  exp_t sb_q[$];

  logic [6:0] ex [6];

  display_scan_controller #(.DIV(DIV), .BLINK_DIV(BLINK)) dut (
    .clk         (clk),
    .rst         (rst),
    .digits_in   (digits_in),
    .blank_lz    (blank_lz),
    .blink_mask  (blink_mask),
    .counter     (counter),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_seg(input logic [3:0] n);
    case (n)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  // Reference model state
  int         m_pre = 0;
  int         m_cnt = 0;
  logic [23:0] m_snap = '0;
  int         m_bcnt = 0;
  logic       m_phase = 1'b0;
  logic [6:0] m_seg = 7'h7F;
  logic       m_dp = 1'b1;
  logic       m_fs = 1'b0;

  // Model steps on every edge and pushes what the DUT should show afterwards.
  always @(posedge clk) begin
    logic       tick, wrap, bwrap, blank;
    logic [3:0] nib;
    exp_t       e;
    if (rst) begin
      m_pre = 0; m_cnt = 0; m_snap = '0; m_bcnt = 0; m_phase = 1'b0;
      m_seg = 7'h7F; m_dp = 1'b1; m_fs = 1'b0;
    end else begin
      tick  = (m_pre == DIV - 1);
      wrap  = tick && (m_cnt == 5);
      bwrap = (m_bcnt == BLINK - 1);
      nib   = 4'((m_snap >> (4 * m_cnt)) & 24'hF);
      blank = ((m_cnt == 5) && blank_lz && (nib == 4'd0)) ||
              (m_phase && blink_mask[m_cnt]) || (nib > 4'd9);
      m_seg = blank ? 7'h7F : ref_seg(nib);
      m_dp  = !((m_cnt == 2) || (m_cnt == 4));
      m_fs  = wrap;
      if (wrap) m_snap = digits_in;
      if (tick) m_cnt = (m_cnt == 5) ? 0 : m_cnt + 1;
      m_pre   = tick ? 0 : m_pre + 1;
      m_phase = m_phase ^ bwrap;
      m_bcnt  = bwrap ? 0 : m_bcnt + 1;
    end
    e.cnt = 3'(m_cnt);
    e.seg = m_seg;
    e.dp  = m_dp;
    e.fs  = m_fs;
    sb_q.push_back(e);
  end

  // Scoreboard: pop one expectation per cycle and compare on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      tests_run += 4;
      assert (counter === e.cnt) else begin
        tests_failed++;
        $error("FAIL sb_counter got %0d want %0d at %0t", counter, e.cnt, $time);
      end
      assert (seg === e.seg) else begin
        tests_failed++;
        $error("FAIL sb_seg got %b want %b at %0t", seg, e.seg, $time);
      end
      assert (dp === e.dp) else begin
        tests_failed++;
        $error("FAIL sb_dp got %b want %b at %0t", dp, e.dp, $time);
      end
      assert (frame_start === e.fs) else begin
        tests_failed++;
        $error("FAIL sb_frame_start got %b want %b at %0t", frame_start, e.fs, $time);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("FAIL %s got 0x%0h want 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic wait_frame(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_start !== 1'b1 && n < 100);
    chk(tag, {31'd0, frame_start}, 32'd1);
  endtask

  task automatic wait_cnt(input logic [2:0] v, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (counter !== v && n < 100);
    chk(tag, {29'd0, counter}, {29'd0, v});
  endtask

  task automatic check_slots(input int n, input string tag);
    logic [2:0] prev;
    prev = counter;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({tag, "_seg"}, {25'd0, seg}, {25'd0, ex[prev]});
      chk({tag, "_dp"}, {31'd0, dp}, ((prev == 3'd2) || (prev == 3'd4)) ? 32'd0 : 32'd1);
      prev = counter;
    end
  endtask

  initial begin
    int blank01, lit01, bad;

    // Reset and first frame
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    digits_in = 24'h123456;
    @(posedge clk); #1;
    chk("rst_counter", {29'd0, counter}, 32'd0);
    chk("rst_seg", {25'd0, seg}, 32'b1000000);
    chk("rst_dp", {31'd0, dp}, 32'd1);
    chk("rst_fs", {31'd0, frame_start}, 32'd0);
    repeat (2) @(posedge clk); #1;
    chk("clk3_counter", {29'd0, counter}, 32'd0);
    @(posedge clk); #1;
    chk("clk4_counter", {29'd0, counter}, 32'd1);
    repeat (19) @(posedge clk); #1;
    chk("clk23_counter", {29'd0, counter}, 32'd5);
    chk("clk23_fs", {31'd0, frame_start}, 32'd0);
    @(posedge clk); #1;
    chk("clk24_counter", {29'd0, counter}, 32'd0);
    chk("clk24_fs", {31'd0, frame_start}, 32'd1);

    // Scan order of 123456
    ex = '{ref_seg(4'd6), ref_seg(4'd5), ref_seg(4'd4), ref_seg(4'd3), ref_seg(4'd2), ref_seg(4'd1)};
    wait_frame("scan_fs");
    check_slots(24, "scan");

    // Snapshot coherency: change inputs mid-frame
    wait_cnt(3'd2, "coh_wait");
    digits_in = 24'h654321;
    check_slots(16, "coh_old");
    chk("coh_fs", {31'd0, frame_start}, 32'd1);
    ex = '{ref_seg(4'd1), ref_seg(4'd2), ref_seg(4'd3), ref_seg(4'd4), ref_seg(4'd5), ref_seg(4'd6)};
    check_slots(24, "coh_new");

    // Leading zero and invalid nibble
    digits_in = 24'h0A2345;
    blank_lz  = 1'b1;
    wait_frame("lz_fs");
    ex = '{ref_seg(4'd5), ref_seg(4'd4), ref_seg(4'd3), ref_seg(4'd2), 7'h7F, 7'h7F};
    check_slots(24, "lz1");
    blank_lz = 1'b0;
    ex = '{ref_seg(4'd5), ref_seg(4'd4), ref_seg(4'd3), ref_seg(4'd2), 7'h7F, 7'b1000000};
    check_slots(24, "lz0");

    // Blink on digits 0 and 1
    digits_in  = 24'h123456;
    blink_mask = 6'b000011;
    wait_frame("blink_fs");
    blank01 = 0; lit01 = 0; bad = 0;
    begin
      logic [2:0] prev;
      prev = counter;
      for (int i = 0; i < 96; i++) begin
        @(negedge clk);
        if (prev < 3'd2) begin
          if (seg === 7'h7F) blank01++;
          else lit01++;
        end else if (seg === 7'h7F) begin
          bad++;
        end
        prev = counter;
      end
    end
    chk("blink_blanked", {31'd0, blank01 > 0}, 32'd1);
    chk("blink_lit", {31'd0, lit01 > 0}, 32'd1);
    chk("blink_other", bad, 32'd0);

    // Reset mid-frame
    blink_mask = '0;
    wait_cnt(3'd3, "mid_wait");
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_counter", {29'd0, counter}, 32'd0);
    chk("mid_seg", {25'd0, seg}, 32'h7F);
    chk("mid_fs", {31'd0, frame_start}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("mid_zero_seg", {25'd0, seg}, 32'b1000000);
      chk("mid_zero_fs", {31'd0, frame_start}, 32'd0);
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
